// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, d_done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, d_done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between fetch (I) and load/store (D) requesters.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise D has fixed priority over I.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  state_t            state, state_nxt;
  port_t             owner, owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pick_d;

  logic              i_done_q, i_done_nxt;
  logic              d_done_q, d_done_nxt;
  logic              mem_en_q, mem_en_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic              busy_q, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  // Arbitration; owner records the port of the current/most recent grant.
`ifdef ARB_RR_EN
  assign pick_d = bus.d_req && (!bus.i_req || (owner == PORT_I));
`else
  assign pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= PORT_I;
      cnt         <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      i_done_q    <= i_done_nxt;
      d_done_q    <= d_done_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      busy_q      <= busy_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      rdata_q     <= rdata_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    rdata_nxt     = rdata_q;

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_nxt  = ISSUE;
          mem_en_nxt = 1'b1;
          if (pick_d) begin
            owner_nxt     = PORT_D;
            mem_we_nxt    = bus.d_we;
            mem_addr_nxt  = bus.d_addr;
            mem_wdata_nxt = bus.d_wdata;
          end else begin
            owner_nxt     = PORT_I;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.i_addr;
          end
        end
      end
      ISSUE: begin
        cnt_nxt   = CNT_W'(MEM_LAT);
        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        // Memory data is valid exactly when the count reaches its last cycle.
        if (cnt == CNT_W'(1)) begin
          state_nxt  = DONE;
          i_done_nxt = (owner == PORT_I);
          d_done_nxt = (owner == PORT_D);
          if (!mem_we_q) begin
            rdata_nxt = bus.mem_rdata;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MEM_LAT=1 and a MEM_LAT=4 instance,
// each with a latency-exact memory model and a done-driven scoreboard.
module tb_mem_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_0BAD;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
  } sb_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  bit   model_last;
  sb_t  sb1[$];
  sb_t  sb4[$];
  sb_t  e1;
  sb_t  e4;
  vec_t vecs[9];

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] def_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
  endfunction

  // Memory models: read data is valid only in the one cycle MEM_LAT edges after the strobe edge.
  logic [31:0] mem1[256];
  bit          wr1[256];
  logic [31:0] rp1;
  bit          rv1;
  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we) begin
      mem1[bus1.mem_addr] <= bus1.mem_wdata;
      wr1[bus1.mem_addr]  <= 1'b1;
    end
    rp1 <= wr1[bus1.mem_addr] ? mem1[bus1.mem_addr] : def_word(bus1.mem_addr);
    rv1 <= bus1.mem_en && !bus1.mem_we;
  end
  assign bus1.mem_rdata = rv1 ? rp1 : JUNK;

  logic [31:0] rp4[4];
  bit          rv4[4];
  always @(posedge clk) begin
    rp4[0] <= def_word(bus4.mem_addr);
    rv4[0] <= bus4.mem_en && !bus4.mem_we;
    for (int k = 1; k < 4; k++) begin
      rp4[k] <= rp4[k-1];
      rv4[k] <= rv4[k-1];
    end
  end
  assign bus4.mem_rdata = rv4[3] ? rp4[3] : JUNK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: each done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus1.i_done || bus1.d_done) begin
      chk("done_excl1", 64'(bus1.i_done & bus1.d_done), 64'd0);
      chk("sb1_pending", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("done_port1", 64'(bus1.d_done), 64'(e1.is_d));
        chk("rdata1", 64'(bus1.rdata), 64'(e1.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.i_done || bus4.d_done) begin
      chk("done_excl4", 64'(bus4.i_done & bus4.d_done), 64'd0);
      chk("sb4_pending", 64'(sb4.size() != 0), 64'd1);
      if (sb4.size() != 0) begin
        e4 = sb4.pop_front();
        chk("done_port4", 64'(bus4.d_done), 64'(e4.is_d));
        chk("rdata4", 64'(bus4.rdata), 64'(e4.rdata));
      end
    end
  end

  // Counts edges until a done pulse on the selected instance (bounded).
  task automatic wait_done(input bit sel4, output int edges);
    bit got;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      got = sel4 ? (bus4.i_done || bus4.d_done) : (bus1.i_done || bus1.d_done);
    end
  endtask

  task automatic chk_zero(input bit sel4);
    chk(sel4 ? "z4_busy"  : "z1_busy",  64'(sel4 ? bus4.busy      : bus1.busy),      64'd0);
    chk(sel4 ? "z4_idone" : "z1_idone", 64'(sel4 ? bus4.i_done    : bus1.i_done),    64'd0);
    chk(sel4 ? "z4_ddone" : "z1_ddone", 64'(sel4 ? bus4.d_done    : bus1.d_done),    64'd0);
    chk(sel4 ? "z4_rdata" : "z1_rdata", 64'(sel4 ? bus4.rdata     : bus1.rdata),     64'd0);
    chk(sel4 ? "z4_en"    : "z1_en",    64'(sel4 ? bus4.mem_en    : bus1.mem_en),    64'd0);
    chk(sel4 ? "z4_we"    : "z1_we",    64'(sel4 ? bus4.mem_we    : bus1.mem_we),    64'd0);
    chk(sel4 ? "z4_addr"  : "z1_addr",  64'(sel4 ? bus4.mem_addr  : bus1.mem_addr),  64'd0);
    chk(sel4 ? "z4_wdata" : "z1_wdata", 64'(sel4 ? bus4.mem_wdata : bus1.mem_wdata), 64'd0);
  endtask

  // One complete access on the MEM_LAT=1 instance, checking strobe, latency and return to IDLE.
  task automatic access1(input vec_t v);
    int lat;
    bit got;
    bus1.i_req   = !v.is_d;
    bus1.i_addr  = v.addr;
    bus1.d_req   = v.is_d;
    bus1.d_we    = v.we;
    bus1.d_addr  = v.addr;
    bus1.d_wdata = v.wdata;
    sb1.push_back('{v.is_d, v.exp_rdata});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk("issue_en", 64'(bus1.mem_en), 64'd1);
        chk("issue_addr", 64'(bus1.mem_addr), 64'(v.addr));
        chk("issue_we", 64'(bus1.mem_we), 64'(v.we));
        if (v.we) chk("issue_wdata", 64'(bus1.mem_wdata), 64'(v.wdata));
      end
      if (lat == 2) chk("en_one_cycle", 64'(bus1.mem_en), 64'd0);
      got = bus1.i_done || bus1.d_done;
    end
    chk("latency1", 64'(lat), 64'd3);
    bus1.i_req = 1'b0;
    bus1.d_req = 1'b0;
    model_last = v.is_d;
    @(posedge clk); #1;
    chk("done_pulse_len", 64'(bus1.i_done | bus1.d_done), 64'd0);
    chk("back_idle", 64'(bus1.busy), 64'd0);
  endtask

  initial begin
    int e;
    bit w;
    vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 8'h30, 32'h0,        32'hC0FFEE30};
    vecs[4] = '{1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 32'hC0FFEE30};
    vecs[5] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 32'h0,        32'hC0FFEEFF};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 32'hFFFFFFFF, 32'hC0FFEEFF};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hFFFFFFFF};

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 8'h50;
    bus1.d_req = 1'b1; bus1.d_addr = 8'h40; bus1.d_we = 1'b0; bus1.d_wdata = 32'h0;
    bus4.i_req = 1'b0; bus4.i_addr = 8'h0;
    bus4.d_req = 1'b0; bus4.d_addr = 8'h0;  bus4.d_we = 1'b0; bus4.d_wdata = 32'h0;

    // Reset held with both requests high, then D must win the first tie.
    repeat (3) @(posedge clk);
    #1;
    chk_zero(1'b0);
    chk_zero(1'b1);
    sb1.push_back('{1'b1, 32'hC0FFEE40});
    sb1.push_back('{1'b0, 32'hC0FFEE50});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_grant_en", 64'(bus1.mem_en), 64'd1);
    chk("first_grant_addr", 64'(bus1.mem_addr), 64'h40);
    wait_done(1'b0, e);
    chk("first_d_lat", 64'(e + 1), 64'd3);
    bus1.d_req = 1'b0;
    wait_done(1'b0, e);
    chk("then_i_lat", 64'(e), 64'd4);
    bus1.i_req = 1'b0;
    model_last = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) access1(vecs[i]);

    // Both requests held: expected grant order from the arbitration model.
    w = model_last;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      w = !w;
`else
      w = 1'b1;
`endif
      sb1.push_back('{w, w ? 32'hC0FFEE61 : 32'hC0FFEE60});
    end
    bus1.i_addr = 8'h60;
    bus1.d_addr = 8'h61;
    bus1.d_we   = 1'b0;
    bus1.i_req  = 1'b1;
    bus1.d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0, e);
      chk("tie_spacing", 64'(e), (k == 0) ? 64'd3 : 64'd4);
    end
    bus1.i_req = 1'b0;
    bus1.d_req = 1'b0;
    model_last = w;
    @(posedge clk); #1;
    chk("tie_idle", 64'(bus1.busy), 64'd0);

    // MEM_LAT=4: plain fetch latency.
    bus4.i_addr = 8'h10;
    bus4.i_req  = 1'b1;
    sb4.push_back('{1'b0, 32'hDEADBEEF});
    wait_done(1'b1, e);
    chk("lat4_read", 64'(e), 64'd6);
    bus4.i_req = 1'b0;
    @(posedge clk); #1;
    chk("lat4_idle", 64'(bus4.busy), 64'd0);

    // Request withdrawn during WAIT still completes.
    bus4.d_addr = 8'h22;
    bus4.d_we   = 1'b0;
    bus4.d_req  = 1'b1;
    sb4.push_back('{1'b1, 32'hC0FFEE22});
    repeat (3) begin @(posedge clk); #1; end
    chk("drop_in_wait_busy", 64'(bus4.busy), 64'd1);
    bus4.d_req = 1'b0;
    wait_done(1'b1, e);
    chk("drop_in_wait_lat", 64'(e + 3), 64'd6);
    @(posedge clk); #1;
    chk("drop_idle", 64'(bus4.busy), 64'd0);

    // Reset asserted during WAIT: outputs clear at once and no done follows.
    bus4.i_addr = 8'h33;
    bus4.i_req  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_wait_busy", 64'(bus4.busy), 64'd1);
    reset      = 1'b0;
    bus4.i_req = 1'b0;
    #1;
    chk_zero(1'b1);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    bus4.i_addr = 8'h44;
    bus4.i_req  = 1'b1;
    sb4.push_back('{1'b0, 32'hC0FFEE44});
    wait_done(1'b1, e);
    chk("post_rst_lat", 64'(e), 64'd6);
    bus4.i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    chk("sb4_drained", 64'(sb4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
